// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if
//   Bundles the EX-stage request and response signals of the iterative
//   multiply/divide sequencer.
//   master: drives start, Funct3, SrcA, SrcB, flush; observes stall, busy, done, Result
//   slave : the sequencer itself (mirror of master)
`timescale 1ns/1ps
interface mdu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;   // an M-op is valid in EX this cycle
    logic [2:0]       Funct3;  // op select
    logic [WIDTH-1:0] SrcA;    // rs1 after forwarding
    logic [WIDTH-1:0] SrcB;    // rs2 after forwarding
    logic             flush;   // kill the in-flight op
    logic             stall;   // freeze PC, IF/ID, ID/EX
    logic             busy;    // sequencer in CALC or FIXUP
    logic             done;    // one-cycle pulse, Result valid
    logic [WIDTH-1:0] Result;  // product half, quotient or remainder

    modport master (
        output start, Funct3, SrcA, SrcB, flush,
        input  stall, busy, done, Result
    );

    modport slave (
        input  start, Funct3, SrcA, SrcB, flush,
        output stall, busy, done, Result
    );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   Iterative RV32M sequencer: radix-2 shift-add multiply or restoring
//   divide over WIDTH cycles, a one-cycle sign fixup, then a one-cycle
//   done pulse with the result. Divide-by-zero and signed overflow resolve
//   at capture and go straight to DONE.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-low reset
//     bus   - mdu_sequencer_if.slave (start/Funct3/SrcA/SrcB/flush in,
//             stall/busy/done/Result out)
`timescale 1ns/1ps
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mdu_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      count_q;
    // Multiply: {upper product, multiplier shifting out at the LSB}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor magnitude
    logic [2:0]         op_q;
    logic               neg_q;    // result needs two's-complement negation
    logic [WIDTH-1:0]   result_q;
    logic               done_q;

    // ---------------- capture-side decode ----------------
    logic             a_signed, b_signed;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             is_div, is_rem;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;
    logic             neg_d;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.Funct3)
            3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                 a_signed = 1'b1;
            default:                ;
        endcase
        is_div   = bus.Funct3[2];
        is_rem   = bus.Funct3[2] & bus.Funct3[1];
        sign_a   = a_signed & bus.SrcA[WIDTH-1];
        sign_b   = b_signed & bus.SrcB[WIDTH-1];
        mag_a    = sign_a ? -bus.SrcA : bus.SrcA;
        mag_b    = sign_b ? -bus.SrcB : bus.SrcB;
        // Remainder takes the dividend's sign; products and quotients take the XOR.
        neg_d    = is_rem ? sign_a : (sign_a ^ sign_b);
        div_zero = is_div && (bus.SrcB == '0);
        div_ovf  = is_div && !bus.Funct3[0]
                   && (bus.SrcA == {1'b1, {(WIDTH-1){1'b0}}})
                   && (bus.SrcB == '1);
        special_res = '0;
        if (div_zero)
            special_res = bus.Funct3[1] ? bus.SrcA : '1;
        else if (div_ovf)
            special_res = bus.Funct3[1] ? '0 : bus.SrcA;
    end

    // ---------------- one iteration ----------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_upper;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_upper = acc_q[0] ? mul_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        // Partial remainder < divisor, so the shifted value is < 2*divisor and
        // the borrow bit alone tells whether the subtraction fits.
        div_ge    = ~div_diff[WIDTH];
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

        if (op_q[2])
            acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        else
            acc_d = {mul_upper, acc_q[WIDTH-1:1]};
    end

    // ---------------- sign fixup and result select ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (op_q[2])
            fix_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q[1:0] == 2'b00)
            fix_res = prod_fix[WIDTH-1:0];
        else
            fix_res = prod_fix[2*WIDTH-1:WIDTH];
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (bus.flush) begin
            // Killed op: no done, Result untouched.
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        op_q  <= bus.Funct3;
                        neg_q <= neg_d;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                        end else begin
                            acc_q   <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                            opnd_q  <= is_div ? mag_b : mag_a;
                            count_q <= '0;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST_COUNT)
                        state_q <= S_FIXUP;
                end
                S_FIXUP: begin
                    result_q <= fix_res;
                    state_q  <= S_DONE;
                    done_q   <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The pipeline must advance on the done cycle, so stall never covers DONE.
    assign bus.stall  = ((state_q == S_IDLE) && bus.start)
                        || (state_q == S_CALC) || (state_q == S_FIXUP);
    assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIXUP);
    assign bus.done   = done_q;
    assign bus.Result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
`timescale 1ns/1ps
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mdu_sequencer_if #(.WIDTH(32)) bus();

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    // done_q updates in the NBA region, so this sees the value of the cycle just ended.
    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op at the current (negedge) time and wait for done.
    // lat counts rising edges from the capture edge up to the done cycle.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int stalls);
        bit got;
        got = 1'b0; lat = 0; stalls = 0; res = '0;
        bus.start = 1'b1; bus.Funct3 = f3; bus.SrcA = a; bus.SrcB = b;
        #1;
        if (bus.stall) stalls++;
        @(posedge clk);
        lat = 1;
        #1;
        bus.start = 1'b0; bus.Funct3 = 3'b111;
        bus.SrcA = 32'hDEADBEEF; bus.SrcB = 32'h0BADF00D;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                res = bus.Result;
                break;
            end
            if (bus.stall) stalls++;
            @(posedge clk);
            lat++;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $error("FAIL timeout: observed no done expected done within 100 cycles");
        end
    endtask

    task automatic op_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int lat, stalls;
        do_op(f3, a, b, res, lat, stalls);
        $display("op %s f3=%b a=%h b=%h -> result=%h latency=%0d stalls=%0d", tag, f3, a, b, res, lat, stalls);
        check({tag, "_res"}, res, exp_res);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, "_stall_at_done"}, {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int lat, stalls, snap;
        bit got;

        bus.start = 1'b0; bus.flush = 1'b0; bus.Funct3 = 3'b000;
        bus.SrcA = '0; bus.SrcB = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall",  {31'd0, bus.stall}, 32'd0);
        check("rst_busy",   {31'd0, bus.busy},  32'd0);
        check("rst_done",   {31'd0, bus.done},  32'd0);
        check("rst_result", bus.Result,         32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Multiply family
        op_check("mul_7x-3",    3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        op_check("mulh_-1x-1",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
        op_check("mulhu_ffxff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        op_check("mulhsu_ffxff",3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        op_check("mulh_min2",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        op_check("mul_lo",      3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 34);

        // Divide family
        op_check("div_-7_2",    3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
        op_check("rem_-7_2",    3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
        op_check("divu_-7_2",   3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 34);
        op_check("remu_-7_2",   3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 34);
        op_check("rem_100_-7",  3'b110, 32'd100,      32'hFFFFFFF9, 32'h00000002, 34);

        // Special cases resolve at capture
        op_check("div_by0",     3'b100, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 1);
        op_check("divu_by0",    3'b101, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 1);
        op_check("remu_5_by0",  3'b111, 32'h00000005, 32'h00000000, 32'h00000005, 1);
        op_check("rem_-5_by0",  3'b110, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1);
        op_check("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        op_check("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        op_check("div_100_-7",  3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);

        // Flush at cycle 10 of a DIVU
        snap = done_cnt;
        bus.start = 1'b1; bus.Funct3 = 3'b101; bus.SrcA = 32'd1000; bus.SrcB = 32'd3;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("flush_busy_before", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        $display("flush mid-DIVU: busy=%b stall=%b result=%h", bus.busy, bus.stall, bus.Result);
        check("flush_busy",   {31'd0, bus.busy},  32'd0);
        check("flush_stall",  {31'd0, bus.stall}, 32'd0);
        check("flush_result", bus.Result,         32'hFFFFFFF2);
        repeat (40) @(negedge clk);
        check("flush_no_done", 32'(done_cnt - snap), 32'd0);

        // flush beats start in the same cycle
        snap = done_cnt;
        bus.start = 1'b1; bus.flush = 1'b1; bus.Funct3 = 3'b000; bus.SrcA = 32'd2; bus.SrcB = 32'd3;
        @(posedge clk); #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
        @(negedge clk);
        $display("flush+start same cycle: busy=%b", bus.busy);
        check("flush_prio_busy", {31'd0, bus.busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("flush_prio_no_done", 32'(done_cnt - snap), 32'd0);

        // Asynchronous reset mid-CALC
        snap = done_cnt;
        bus.start = 1'b1; bus.Funct3 = 3'b000; bus.SrcA = 32'd5; bus.SrcB = 32'd6;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rstmid_busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        $display("reset mid-CALC: stall=%b busy=%b done=%b result=%h", bus.stall, bus.busy, bus.done, bus.Result);
        check("rstmid_stall",  {31'd0, bus.stall}, 32'd0);
        check("rstmid_busy",   {31'd0, bus.busy},  32'd0);
        check("rstmid_done",   {31'd0, bus.done},  32'd0);
        check("rstmid_result", bus.Result,         32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("rstmid_no_done", 32'(done_cnt - snap), 32'd0);

        // Back-to-back: start held into the DONE cycle
        do_op(3'b000, 32'h00000007, 32'hFFFFFFFD, res, lat, stalls);
        $display("b2b first: result=%h latency=%0d", res, lat);
        check("b2b_first_res", res, 32'hFFFFFFEB);
        do_op(3'b000, 32'd6, 32'd7, res, lat, stalls);
        $display("b2b second: result=%h cycles_after_first_done=%0d", res, lat);
        check("b2b_second_res", res, 32'd42);
        check("b2b_gap", 32'(lat), 32'd34);
        @(negedge clk);

        // start while busy is ignored
        snap = done_cnt;
        got = 1'b0;
        bus.start = 1'b1; bus.Funct3 = 3'b101; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 begin bus.start = 1'b1; bus.Funct3 = 3'b000; bus.SrcA = 32'd3; bus.SrcB = 32'd3; end
        @(posedge clk); #1 bus.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin got = 1'b1; res = bus.Result; break; end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $error("FAIL busy_ign_timeout: observed no done expected done");
        end
        $display("start while busy: result=%h", res);
        check("busy_ign_res", res, 32'd14);
        repeat (40) @(negedge clk);
        check("busy_ign_done_count", 32'(done_cnt - snap), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
